// File: rtl/iot_pkg.sv
// Shared types and width helpers for the IoT event path (arbiter and monitor).
package iot_pkg;

    localparam int IOT_N_DEV_DEFAULT = 8;

    function automatic int iot_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int iot_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int IOT_ID_W_DEFAULT  = iot_id_w(IOT_N_DEV_DEFAULT);
    localparam int IOT_CNT_W_DEFAULT = iot_cnt_w(IOT_N_DEV_DEFAULT);

    typedef struct packed {
        logic                        change;
        logic                        on_off;
        logic [IOT_ID_W_DEFAULT-1:0] dev_id;
    } iot_event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: lowest requesting index at or above ptr, wrapping.
module rr_arbiter
    import iot_pkg::*;
#(
    parameter int N  = IOT_N_DEV_DEFAULT,
    parameter int IW = iot_id_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    int j;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/iot_event_arbiter.sv
// Per-device on/off edge capture with one pending net event per device, serialised round-robin.
// Optional IOT_EVQ_SYNC_EN adds a 2-flop synchroniser on dev_status.
module iot_event_arbiter
    import iot_pkg::*;
#(
    parameter int N_DEV = IOT_N_DEV_DEFAULT,
    parameter int ID_W  = iot_id_w(N_DEV),
    parameter int CNT_W = iot_cnt_w(N_DEV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_status,
    output logic             change,
    output logic             on_off,
    output logic [ID_W-1:0]  dev_id,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             busy
);

    logic [N_DEV-1:0] stat;
    logic [N_DEV-1:0] status_q;
    logic [N_DEV-1:0] rise, fall;
    logic [N_DEV-1:0] pending_q, pending_d;
    logic [N_DEV-1:0] dir_q, dir_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             change_q, on_off_q;
    logic [ID_W-1:0]  dev_id_q;
    logic             gnt_valid;
    logic [ID_W-1:0]  gnt_idx;
    logic             granted;
    int               nxt;

`ifdef IOT_EVQ_SYNC_EN
    logic [N_DEV-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dev_status;
            sync2_q <= sync1_q;
        end
    end

    assign stat = sync2_q;
`else
    assign stat = dev_status;
`endif

    assign rise = stat & ~status_q;
    assign fall = ~stat & status_q;

    rr_arbiter #(.N(N_DEV), .IW(ID_W)) u_rr (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // An opposite edge on a still-queued device nets to zero, so the event is dropped.
    always_comb begin
        pending_d = pending_q;
        dir_d     = dir_q;
        cnt_d     = '0;
        rr_ptr_d  = rr_ptr_q;
        granted   = 1'b0;
        nxt       = 0;
        for (int i = 0; i < N_DEV; i++) begin
            granted = gnt_valid && (gnt_idx == ID_W'(i));
            if (rise[i] || fall[i]) begin
                if (!pending_q[i] || granted) begin
                    pending_d[i] = 1'b1;
                    dir_d[i]     = rise[i];
                end else if (rise[i] != dir_q[i]) begin
                    pending_d[i] = 1'b0;
                end
            end else if (granted) begin
                pending_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < N_DEV; i++) begin
            cnt_d = cnt_d + CNT_W'(pending_d[i]);
        end
        if (gnt_valid) begin
            nxt      = int'(gnt_idx) + 1;
            rr_ptr_d = (nxt >= N_DEV) ? '0 : ID_W'(nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q  <= '0;
            pending_q <= '0;
            dir_q     <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            change_q  <= 1'b0;
            on_off_q  <= 1'b0;
            dev_id_q  <= '0;
        end else begin
            status_q  <= stat;
            pending_q <= pending_d;
            dir_q     <= dir_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            change_q  <= gnt_valid;
            if (gnt_valid) begin
                on_off_q <= dir_q[gnt_idx];
                dev_id_q <= gnt_idx;
            end
        end
    end

    assign change      = change_q;
    assign on_off      = on_off_q;
    assign dev_id      = dev_id_q;
    assign pending_cnt = cnt_q;
    assign busy        = (cnt_q != '0) || change_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Scoreboarded bench for iot_event_arbiter: directed scenarios plus random toggling.
module tb_iot_event_arbiter;

    localparam int N = 8;
`ifdef IOT_EVQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dev_status = 8'h00;
    logic       change, on_off;
    logic [2:0] dev_id;
    logic [3:0] pending_cnt;
    logic       busy;

    always #5 clk = ~clk;

    iot_event_arbiter #(.N_DEV(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .dev_status  (dev_status),
        .change      (change),
        .on_off      (on_off),
        .dev_id      (dev_id),
        .pending_cnt (pending_cnt),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;

    // Model: a device owes an event exactly when its sampled level differs from what
    // the monitor has been told; each report carries the level the device was at.
    logic [7:0] level = '0;
    logic [7:0] told  = '0;
    int         ptr   = 0;
    int         m_cnt = 0;
    bit         m_gnt = 0;
    bit         m_rst_edge = 0;
    int         exp_q[$];
    int         obs_q[$];
    int         exp_list[$];
    int         acc = 0;
`ifdef IOT_EVQ_SYNC_EN
    logic [7:0] s1 = '0, s2 = '0;
`endif

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(posedge clk) begin : model
        logic [7:0] stat_now;
        int gi;
        if (rst) begin
            level = '0;
            told  = '0;
            ptr   = 0;
            exp_q.delete();
            m_cnt = 0;
            m_gnt = 0;
            m_rst_edge = 1;
`ifdef IOT_EVQ_SYNC_EN
            s1 = '0;
            s2 = '0;
`endif
        end else begin
`ifdef IOT_EVQ_SYNC_EN
            stat_now = s2;
            s2 = s1;
            s1 = dev_status;
`else
            stat_now = dev_status;
`endif
            gi = -1;
            for (int k = 0; k < N; k++) begin
                if (gi < 0 && level[(ptr + k) % N] != told[(ptr + k) % N]) gi = (ptr + k) % N;
            end
            if (gi >= 0) begin
                exp_q.push_back(gi * 2 + int'(level[gi]));
                told[gi] = level[gi];
                ptr = (gi + 1) % N;
            end
            level = stat_now;
            m_cnt = $countones(level ^ told);
            m_gnt = (gi >= 0);
            m_rst_edge = 0;
        end
    end

    always @(posedge clk) begin : monitor
        int e;
        #1;
        if (m_rst_edge) begin
            acc = 0;
            chk("rst_change", int'(change), 0);
            chk("rst_pending_cnt", int'(pending_cnt), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_dev_id", int'(dev_id), 0);
            chk("rst_on_off", int'(on_off), 0);
        end else begin
            if (change) begin
                obs_q.push_back(int'(dev_id) * 2 + int'(on_off));
                acc += on_off ? 1 : -1;
                if (exp_q.size() == 0) begin
                    chk("spurious_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_dev_id", int'(dev_id), e / 2);
                    chk("pulse_on_off", int'(on_off), e % 2);
                end
            end else if (exp_q.size() != 0) begin
                chk("missing_pulse", 0, 1);
                exp_q.delete();
            end
            chk("pending_cnt", int'(pending_cnt), m_cnt);
            chk("busy", int'(busy), int'(m_cnt != 0 || m_gnt));
            if (!busy) chk("idle_count", acc, $countones(level));
        end
    end

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_pending(input int budget);
        int n = 0;
        @(negedge clk);
        while (pending_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_obs(input string name);
        tests++;
        if (obs_q.size() != exp_list.size()) begin
            fails++;
            $display("FAIL %s: got %0d events expected %0d", name, obs_q.size(), exp_list.size());
        end else begin
            for (int i = 0; i < exp_list.size(); i++) begin
                if (obs_q[i] != exp_list[i]) begin
                    fails++;
                    $display("FAIL %s: event %0d got id%0d/dir%0d expected id%0d/dir%0d",
                             name, i, obs_q[i] / 2, obs_q[i] % 2, exp_list[i] / 2, exp_list[i] % 2);
                    break;
                end
            end
        end
        obs_q.delete();
        exp_list.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        dev_status = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        wait_pending(10);
        chk("t1_cnt_after_release", int'(pending_cnt), 8);
        wait_idle(40);
        for (int i = 0; i < 8; i++) exp_list.push_back(i * 2 + 1);
        check_obs("t1_all_on");

        dev_status = 8'h00;
        wait_idle(40);
        for (int i = 0; i < 8; i++) exp_list.push_back(i * 2);
        check_obs("t1_all_off");

        // Device 5 falls again while still queued behind 0..4.
        dev_status = 8'h3F;
        repeat (LAT) @(negedge clk);
        dev_status = 8'h1F;
        wait_idle(40);
        for (int i = 0; i < 5; i++) exp_list.push_back(i * 2 + 1);
        check_obs("t3_cancel");

        dev_status = 8'h00;
        wait_idle(40);
        for (int i = 0; i < 5; i++) exp_list.push_back(i * 2);
        check_obs("t3_off");

        dev_status = 8'h08;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!change && n < 10);
        chk("t2_latency", n, LAT);
        chk("t2_dev_id", int'(dev_id), 3);
        chk("t2_on_off", int'(on_off), 1);
        @(negedge clk);
        chk("t2_single_cycle", int'(change), 0);
        wait_idle(20);
        exp_list.push_back(3 * 2 + 1);
        check_obs("t2_single");

        dev_status = 8'h28;
        wait_idle(20);
        dev_status = 8'hAA;
        wait_idle(20);
        dev_status = 8'hAE;
        wait_idle(20);
        dev_status = 8'hAA;
        wait_idle(20);
        exp_list.push_back(5 * 2 + 1);
        exp_list.push_back(7 * 2 + 1);
        exp_list.push_back(1 * 2 + 1);
        exp_list.push_back(2 * 2 + 1);
        exp_list.push_back(2 * 2);
        check_obs("t4_wrap_order");

        dev_status = 8'hB5;
        wait_pending(10);
        chk("t5_cnt_before_rst", int'(pending_cnt), 5);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_change", int'(change), 0);
        chk("t5_rst_cnt", int'(pending_cnt), 0);
        rst = 1'b0;
        obs_q.delete();
        wait_idle(40);
        exp_list.push_back(0 * 2 + 1);
        exp_list.push_back(2 * 2 + 1);
        exp_list.push_back(4 * 2 + 1);
        exp_list.push_back(5 * 2 + 1);
        exp_list.push_back(7 * 2 + 1);
        check_obs("t5_rereport");

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) dev_status[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) dev_status[$urandom_range(0, 7)] ^= 1'b1;
        end
        wait_idle(100);
        chk("t6_final_count", acc, $countones(dev_status));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
